sdram_burst_master: RTL

- Host-side initiator for the SDRAM controller's host interface. It issues WR/RD burst requests with ADDR/LENGTH.
- Write path: supplies write data on IN_REQ from an upstream show-ahead FIFO.
- Read path: captures read data on OUT_VALID into a downstream FIFO.
- Sits between the video/USB stream FIFOs and the SDRAM controller. Arbitrates write and read bursts round-robin over two circular address windows.

---
 rtl/sdram_master_pkg.sv | 16 +
 rtl/sdram_addr_gen.sv | 34 +++
 rtl/sdram_burst_master.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/sdram_master_pkg.sv
// Shared types and defaults for the SDRAM burst master.
package sdram_master_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ACT,
        S_WR_REL,
        S_RD_ACT,
        S_RD_REL
    } state_t;

    localparam int DEF_ASIZE     = 22;
    localparam int DEF_DSIZE     = 16;
    localparam int DEF_BURST_LEN = 8;
    localparam int DEF_RD_LAT    = 1;
    localparam int WDOG_LIMIT    = 1023;
endpackage

// File: rtl/sdram_addr_gen.sv
// One circular burst pointer: reload to base, or step by a burst and wrap
// back to base when the next burst would run past max.
module sdram_addr_gen
    import sdram_master_pkg::*;
#(
    parameter int ASIZE     = DEF_ASIZE,
    parameter int BURST_LEN = DEF_BURST_LEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             advance,
    input  logic [ASIZE-1:0] base,
    input  logic [ASIZE-1:0] max,
    output logic [ASIZE-1:0] ptr
);
    localparam logic [ASIZE:0] STEP = (ASIZE+1)'(BURST_LEN);
    localparam logic [ASIZE:0] SPAN = (ASIZE+1)'(BURST_LEN - 1);

    logic [ASIZE:0] nxt, nxt_end;

    // One extra bit so the end-of-burst compare never loses a carry.
    assign nxt     = {1'b0, ptr} + STEP;
    assign nxt_end = nxt + SPAN;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= '0;
        else if (load)
            ptr <= base;
        else if (advance)
            ptr <= (nxt_end > {1'b0, max}) ? base : nxt[ASIZE-1:0];
    end
endmodule

// File: rtl/sdram_burst_master.sv
// Round-robin write/read burst initiator for the SDRAM controller host port.
// Optional BURST_WATCHDOG_EN aborts stuck bursts and raises a sticky ERR.
module sdram_burst_master
    import sdram_master_pkg::*;
#(
    parameter int ASIZE     = DEF_ASIZE,
    parameter int DSIZE     = DEF_DSIZE,
    parameter int BURST_LEN = DEF_BURST_LEN,
    parameter int RD_LAT    = DEF_RD_LAT
) (
    input  logic               REF_CLK,
    input  logic               RESET,
    input  logic               ADDR_LOAD,
    input  logic               RD_EN,
    input  logic [ASIZE-1:0]   WR_BASE,
    input  logic [ASIZE-1:0]   WR_MAX,
    input  logic [ASIZE-1:0]   RD_BASE,
    input  logic [ASIZE-1:0]   RD_MAX,
    input  logic [DSIZE-1:0]   WR_DATA,
    input  logic [8:0]         WR_LEVEL,
    output logic               WR_POP,
    output logic [DSIZE-1:0]   RD_DATA,
    output logic               RD_PUSH,
    input  logic [8:0]         RD_SPACE,
    output logic [ASIZE-1:0]   ADDR,
    output logic               WR,
    output logic               RD,
    output logic [7:0]         LENGTH,
    output logic [DSIZE-1:0]   DATAIN,
    output logic [DSIZE/8-1:0] DM,
    input  logic               DONE,
    input  logic               IN_REQ,
    input  logic               OUT_VALID,
    input  logic [DSIZE-1:0]   DATAOUT,
    output logic               BUSY,
    output logic               ERR
);
    localparam logic [8:0] BL = 9'(BURST_LEN);

    state_t           state;
    logic [ASIZE-1:0] wr_ptr, rd_ptr;
    logic [8:0]       wcnt, rcnt;
    logic             last_wr, vld_d, rd_cap, leave, load;
    logic             wr_elig, rd_elig, grant_w, grant_r, wdone, rdone;

    assign LENGTH = 8'(BURST_LEN);
    assign DM     = '0;

    assign wr_elig = WR_LEVEL >= BL;
    assign rd_elig = RD_EN && (RD_SPACE >= BL);
    assign grant_w = wr_elig && (!rd_elig || !last_wr);
    assign grant_r = rd_elig && !grant_w;
    assign load    = (state == S_IDLE) && ADDR_LOAD;

    assign WR_POP = (state == S_WR_ACT) && IN_REQ && (wcnt < BL);
    assign DATAIN = (state == S_WR_ACT) ? WR_DATA : '0;
    assign rd_cap = (state == S_RD_ACT) && vld_d && (rcnt < BL);
    assign wdone  = (wcnt + 9'(WR_POP)) == BL;
    assign rdone  = (rcnt + 9'(rd_cap)) == BL;

    generate
        if (RD_LAT == 0) begin : g_vld0
            assign vld_d = OUT_VALID;
        end else begin : g_vld
            logic [RD_LAT-1:0] vld_pipe;
            always_ff @(posedge REF_CLK or posedge RESET) begin
                if (RESET) vld_pipe <= '0;
                else       vld_pipe <= (vld_pipe << 1) | RD_LAT'(OUT_VALID);
            end
            assign vld_d = vld_pipe[RD_LAT-1];
        end
    endgenerate

    always_comb begin
        leave = 1'b0;
        case (state)
            S_WR_ACT:           leave = DONE && wdone;
            S_RD_ACT:           leave = DONE && rdone;
            S_WR_REL, S_RD_REL: leave = !DONE;
            default:            leave = 1'b0;
        endcase
    end

    sdram_addr_gen #(.ASIZE(ASIZE), .BURST_LEN(BURST_LEN)) u_wr_ptr (
        .clk(REF_CLK), .rst(RESET), .load(load),
        .advance((state == S_WR_REL) && !DONE),
        .base(WR_BASE), .max(WR_MAX), .ptr(wr_ptr)
    );

    sdram_addr_gen #(.ASIZE(ASIZE), .BURST_LEN(BURST_LEN)) u_rd_ptr (
        .clk(REF_CLK), .rst(RESET), .load(load),
        .advance((state == S_RD_REL) && !DONE),
        .base(RD_BASE), .max(RD_MAX), .ptr(rd_ptr)
    );

`ifdef BURST_WATCHDOG_EN
    logic [9:0] wd;
    logic       err_r;
    assign ERR = err_r;
`else
    assign ERR = 1'b0;
`endif

    always_ff @(posedge REF_CLK or posedge RESET) begin
        if (RESET) begin
            state   <= S_IDLE;
            WR      <= 1'b0;
            RD      <= 1'b0;
            ADDR    <= '0;
            BUSY    <= 1'b0;
            RD_PUSH <= 1'b0;
            RD_DATA <= '0;
            wcnt    <= '0;
            rcnt    <= '0;
            last_wr <= 1'b0;
`ifdef BURST_WATCHDOG_EN
            wd      <= '0;
            err_r   <= 1'b0;
`endif
        end else begin
            RD_PUSH <= rd_cap;
            if (rd_cap) begin
                RD_DATA <= DATAOUT;
                rcnt    <= rcnt + 9'd1;
            end
            if (WR_POP) wcnt <= wcnt + 9'd1;

            case (state)
                S_IDLE: if (!ADDR_LOAD) begin
                    if (grant_w) begin
                        state   <= S_WR_ACT;
                        WR      <= 1'b1;
                        ADDR    <= wr_ptr;
                        BUSY    <= 1'b1;
                        wcnt    <= '0;
                        last_wr <= 1'b1;
                    end else if (grant_r) begin
                        state   <= S_RD_ACT;
                        RD      <= 1'b1;
                        ADDR    <= rd_ptr;
                        BUSY    <= 1'b1;
                        rcnt    <= '0;
                        last_wr <= 1'b0;
                    end
                end
                S_WR_ACT: if (leave) begin
                    state <= S_WR_REL;
                    WR    <= 1'b0;
                end
                S_RD_ACT: if (leave) begin
                    state <= S_RD_REL;
                    RD    <= 1'b0;
                end
                default: if (leave) begin
                    state <= S_IDLE;
                    BUSY  <= 1'b0;
                end
            endcase

`ifdef BURST_WATCHDOG_EN
            // A normal exit always wins over a coincident timeout.
            if (state == S_IDLE)
                wd <= '0;
            else if (!leave) begin
                if (wd == 10'(WDOG_LIMIT - 1)) begin
                    state <= S_IDLE;
                    WR    <= 1'b0;
                    RD    <= 1'b0;
                    BUSY  <= 1'b0;
                    err_r <= 1'b1;
                end else
                    wd <= wd + 10'd1;
            end
`endif
        end
    end
endmodule
